// File: rtl/mat_xfer_pkg.sv
// Shared types and constants for the matrix-transfer host master.
package mat_xfer_pkg;

    localparam int unsigned MAT_N    = 5;
    localparam int unsigned ELEMS    = MAT_N * MAT_N;
    localparam int unsigned IDX_IDLE = 0;
    localparam logic [15:0] CYC_MAX  = 16'hFFFF;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_SETTLE,
        S_RD_WAIT,
        S_OUT,
        S_DONE
    } state_t;

endpackage

// File: rtl/mat_xfer_cyc_cnt.sv
// Saturating 16-bit job cycle counter: start loads 1, enable steps, otherwise frozen.
module mat_xfer_cyc_cnt
    import mat_xfer_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        enable,
    output logic [15:0] count
);

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == CYC_MAX) ? v : v + 16'd1;
    endfunction

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (start) begin
            count <= 16'd1;
        end else if (enable) begin
            count <= sat_inc(count);
        end
    end

endmodule

// File: rtl/mat_xfer_master.sv
// Host-side master: streams an N x N matrix into the indexed accelerator port,
// reads every result back by index and forwards it on a valid/ready stream.
module mat_xfer_master
    import mat_xfer_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int N      = MAT_N,
    parameter int IDX_W  = 5,
    parameter int RD_LAT = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic [DATA_W-1:0] s_data,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [DATA_W-1:0] m_data,
    output logic              m_last,
    output logic [IDX_W-1:0]  acc_rcv_idx,
    output logic [DATA_W-1:0] acc_rcv_data,
    output logic [IDX_W-1:0]  acc_snd_idx,
    input  logic [DATA_W-1:0] acc_snd_data,
    output logic              busy,
    output logic              done,
    output logic [15:0]       cycles
);

    localparam int NN     = N * N;
    localparam int WCNT_W = (RD_LAT < 2) ? 1 : $clog2(RD_LAT + 1);

    localparam logic [IDX_W-1:0]  IDX_NONE = IDX_W'(IDX_IDLE);
    localparam logic [IDX_W-1:0]  LAST_POS = IDX_W'(NN - 1);
    localparam logic [WCNT_W-1:0] WCNT_RLD = WCNT_W'(RD_LAT);

    state_t              state;
    state_t              state_nxt;
    logic [IDX_W-1:0]    k;
    logic [IDX_W-1:0]    j;
    logic [WCNT_W-1:0]   wcnt;
    logic                s_accept;
    logic                m_hs;
    logic                rd_fire;
    logic                cnt_start;
    logic                cnt_en;

    assign s_accept  = s_valid && s_ready;
    assign m_hs      = m_valid && m_ready;
    assign rd_fire   = (state == S_RD_WAIT) && (wcnt == WCNT_W'(1));
    assign cnt_start = (state == S_IDLE) && s_accept;
    assign cnt_en    = (state == S_LOAD) || (state == S_SETTLE) ||
                       (state == S_RD_WAIT) || (state == S_OUT);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        busy      = (state != S_IDLE);
        done      = (state == S_DONE);
        case (state)
            S_IDLE: begin
                if (s_accept) begin
                    state_nxt = (NN == 1) ? S_SETTLE : S_LOAD;
                end
            end
            S_LOAD: begin
                if (s_accept && (k == LAST_POS)) begin
                    state_nxt = S_SETTLE;
                end
            end
            S_SETTLE: begin
                state_nxt = S_RD_WAIT;
            end
            S_RD_WAIT: begin
                if (wcnt == WCNT_W'(1)) begin
                    state_nxt = S_OUT;
                end
            end
            S_OUT: begin
                if (m_hs) begin
                    state_nxt = (j == LAST_POS) ? S_DONE : S_RD_WAIT;
                end
            end
            S_DONE: begin
                state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    // Write-side and read-side index registers; each is held until its own handshake,
    // and the write index is parked at idle before the read index leaves idle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s_ready      <= 1'b0;
            m_valid      <= 1'b0;
            m_last       <= 1'b0;
            acc_rcv_idx  <= IDX_NONE;
            acc_rcv_data <= '0;
            acc_snd_idx  <= IDX_NONE;
            k            <= '0;
            j            <= '0;
            wcnt         <= '0;
        end else begin
            s_ready <= (state_nxt == S_IDLE) || (state_nxt == S_LOAD);
            case (state)
                S_IDLE: begin
                    if (s_accept) begin
                        acc_rcv_idx  <= IDX_W'(1);
                        acc_rcv_data <= s_data;
                        k            <= IDX_W'(1);
                    end
                end
                S_LOAD: begin
                    if (s_accept) begin
                        acc_rcv_idx  <= k + IDX_W'(1);
                        acc_rcv_data <= s_data;
                        k            <= k + IDX_W'(1);
                    end
                end
                S_SETTLE: begin
                    acc_rcv_idx <= IDX_NONE;
                    acc_snd_idx <= IDX_W'(1);
                    j           <= '0;
                    wcnt        <= WCNT_RLD;
                end
                S_RD_WAIT: begin
                    wcnt <= wcnt - WCNT_W'(1);
                    if (wcnt == WCNT_W'(1)) begin
                        m_valid <= 1'b1;
                        m_last  <= (j == LAST_POS);
                    end
                end
                S_OUT: begin
                    if (m_hs) begin
                        m_valid <= 1'b0;
                        if (j == LAST_POS) begin
                            m_last      <= 1'b0;
                            acc_snd_idx <= IDX_NONE;
                        end else begin
                            acc_snd_idx <= j + IDX_W'(2);
                            j           <= j + IDX_W'(1);
                            wcnt        <= WCNT_RLD;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Result capture: read data is taken RD_LAT cycles after the read index moved.
    always_ff @(posedge clk) begin
        if (rd_fire) begin
            m_data <= acc_snd_data;
        end
    end

    mat_xfer_cyc_cnt u_cyc_cnt (
        .clk    (clk),
        .reset  (reset),
        .start  (cnt_start),
        .enable (cnt_en),
        .count  (cycles)
    );

endmodule

// File: tb/tb_mat_xfer_master.sv
// Directed bench: two masters (RD_LAT 1 and 3) each driving a 5x5 transpose accelerator model.
module tb_mat_xfer_master;

    logic        clk;
    logic        reset;
    logic        s_valid  [2];
    logic        s_ready  [2];
    logic [31:0] s_data   [2];
    logic        m_valid  [2];
    logic        m_ready  [2];
    logic [31:0] m_data   [2];
    logic        m_last   [2];
    logic [4:0]  rcv_idx  [2];
    logic [31:0] rcv_data [2];
    logic [4:0]  snd_idx  [2];
    logic        busy     [2];
    logic        done     [2];
    logic [15:0] cycles   [2];

    int n_assert;
    int n_fail;
    int meas;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    for (genvar g = 0; g < 2; g++) begin : g_dut
        localparam int LAT = (g == 0) ? 1 : 3;
        logic [31:0] mem [32];
        logic [4:0]  prev_idx;
        int          age;
        int          age_eff;
        logic [31:0] rd_data;

        mat_xfer_master #(.DATA_W(32), .N(5), .IDX_W(5), .RD_LAT(LAT)) u_dut (
            .clk          (clk),
            .reset        (reset),
            .s_valid      (s_valid[g]),
            .s_ready      (s_ready[g]),
            .s_data       (s_data[g]),
            .m_valid      (m_valid[g]),
            .m_ready      (m_ready[g]),
            .m_data       (m_data[g]),
            .m_last       (m_last[g]),
            .acc_rcv_idx  (rcv_idx[g]),
            .acc_rcv_data (rcv_data[g]),
            .acc_snd_idx  (snd_idx[g]),
            .acc_snd_data (rd_data),
            .busy         (busy[g]),
            .done         (done[g]),
            .cycles       (cycles[g])
        );

        // Transpose accelerator: element at read index s is input element (s%5)*5 + s/5 (0-based).
        always @(posedge clk) begin
            if (rcv_idx[g] != 5'd0) begin
                mem[(({27'd0, rcv_idx[g]} - 1) % 5) * 5 + (({27'd0, rcv_idx[g]} - 1) / 5) + 1] <= rcv_data[g];
            end
            prev_idx <= snd_idx[g];
            age      <= (snd_idx[g] != prev_idx) ? 1 : ((age < 1000) ? age + 1 : age);
        end

        always_comb begin
            age_eff = age;
            if (snd_idx[g] != prev_idx) age_eff = 0;
            rd_data = 32'hBAD0_0000 | 32'(age_eff);
            if (snd_idx[g] != 5'd0 && age_eff >= LAT - 1) rd_data = mem[snd_idx[g]];
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_assert++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic check_reset(input int d, input string t);
        check($sformatf("%s d%0d s_ready", t, d), 32'(s_ready[d]), 32'd0);
        check($sformatf("%s d%0d m_valid", t, d), 32'(m_valid[d]), 32'd0);
        check($sformatf("%s d%0d m_last", t, d), 32'(m_last[d]), 32'd0);
        check($sformatf("%s d%0d rcv_idx", t, d), 32'(rcv_idx[d]), 32'd0);
        check($sformatf("%s d%0d rcv_data", t, d), rcv_data[d], 32'd0);
        check($sformatf("%s d%0d snd_idx", t, d), 32'(snd_idx[d]), 32'd0);
        check($sformatf("%s d%0d busy", t, d), 32'(busy[d]), 32'd0);
        check($sformatf("%s d%0d done", t, d), 32'(done[d]), 32'd0);
        check($sformatf("%s d%0d cycles", t, d), 32'(cycles[d]), 32'd0);
    endtask

    // One full job on DUT d; input i carries base+i, expected output j is base+(j%5)*5+j/5.
    task automatic run_job(input int d, input int base, input bit gap, input int mstall,
                           input int first_stall, input bit junk, input int budget,
                           output int edges_out);
        int n_in = 0, n_out = 0, cyc = 0, rd_cyc = 0, edges = 0, done_cnt = 0;
        int stall_left = 0, post = 0, err_port = 0, err_sready = 0, err_stable = 0;
        bit started = 0, finished = 0, pending = 0, held = 0, hs_last = 0;
        logic [31:0] held_data;
        logic        held_last;
        held_data = '0;
        held_last = 1'b0;
        while (cyc < budget && post < 3) begin
            @(negedge clk);
            cyc++;
            if (n_in == 0) begin
                if (rcv_idx[d] != 5'd0 || snd_idx[d] != 5'd0) err_port++;
            end else if (n_in < 25) begin
                if (int'(rcv_idx[d]) != n_in || rcv_data[d] != 32'(base + n_in - 1) ||
                    snd_idx[d] != 5'd0) err_port++;
                if (!s_ready[d]) err_sready++;
            end else begin
                rd_cyc++;
                if (rd_cyc == 1) begin
                    if (rcv_idx[d] != 5'd25 || rcv_data[d] != 32'(base + 24) ||
                        snd_idx[d] != 5'd0) err_port++;
                end else if (n_out < 25) begin
                    if (rcv_idx[d] != 5'd0 || int'(snd_idx[d]) != n_out + 1) err_port++;
                end else if (rcv_idx[d] != 5'd0 || snd_idx[d] != 5'd0) begin
                    err_port++;
                end
            end
            if (rcv_idx[d] != 5'd0 && snd_idx[d] != 5'd0) err_port++;
            if (done[d]) done_cnt++;
            if (held && (!m_valid[d] || m_data[d] !== held_data || m_last[d] !== held_last))
                err_stable++;
            if (finished) post++;

            s_valid[d] = !finished && ((n_in < 25) ? (!gap || (cyc % 2) == 0) : junk);
            s_data[d]  = (n_in < 25) ? 32'(base + n_in) : 32'hDEAD_BEEF;
            if (m_valid[d] && !pending) begin
                pending    = 1;
                stall_left = (n_out == 0) ? first_stall : mstall;
            end
            m_ready[d] = (stall_left == 0);
            if (stall_left > 0) stall_left--;
            held      = m_valid[d] && !m_ready[d];
            held_data = m_data[d];
            held_last = m_last[d];

            if (s_valid[d] && s_ready[d]) begin
                if (n_in == 25) err_sready++;
                else n_in++;
                started = 1;
            end
            if (m_valid[d] && m_ready[d]) begin
                check($sformatf("d%0d b%0d out%0d data", d, base, n_out), m_data[d],
                      32'(base + (n_out % 5) * 5 + n_out / 5));
                check($sformatf("d%0d b%0d out%0d last", d, base, n_out), 32'(m_last[d]),
                      32'(n_out == 24));
                pending = 0;
                n_out++;
                if (n_out == 25) hs_last = 1;
            end
            if (started && !finished) edges++;
            if (hs_last) finished = 1;
        end
        s_valid[d] = 1'b0;
        check($sformatf("d%0d b%0d job finished in budget", d, base), 32'(finished), 32'd1);
        check($sformatf("d%0d b%0d port sequence errors", d, base), 32'(err_port), 32'd0);
        check($sformatf("d%0d b%0d s_ready errors", d, base), 32'(err_sready), 32'd0);
        check($sformatf("d%0d b%0d stall stability errors", d, base), 32'(err_stable), 32'd0);
        check($sformatf("d%0d b%0d done pulses", d, base), 32'(done_cnt), 32'd1);
        check($sformatf("d%0d b%0d busy after job", d, base), 32'(busy[d]), 32'd0);
        check($sformatf("d%0d b%0d s_ready after job", d, base), 32'(s_ready[d]), 32'd1);
        edges_out = edges;
    endtask

    initial begin
        int got;
        n_assert = 0;
        n_fail   = 0;
        reset    = 1'b0;
        for (int d = 0; d < 2; d++) begin
            s_valid[d] = 1'b0;
            s_data[d]  = '0;
            m_ready[d] = 1'b0;
        end
        #1 reset = 1'b1;
        #1;
        check_reset(0, "por");
        check_reset(1, "por");
        repeat (2) @(negedge clk);
        reset = 1'b0;

        run_job(0, 1, 1'b0, 0, 0, 1'b0, 2000, meas);
        check("j1 cycles", 32'(cycles[0]), 32'd76);

        run_job(0, 1, 1'b1, 3, 3, 1'b1, 4000, meas);
        check("j2 cycles vs edges", 32'(cycles[0]), 32'(meas));

        run_job(1, 1, 1'b0, 0, 0, 1'b0, 2000, meas);
        check("j3 lat3 cycles", 32'(cycles[1]), 32'd126);

        got = 0;
        for (int c = 0; c < 200 && got < 12; c++) begin
            @(negedge clk);
            s_valid[0] = 1'b1;
            s_data[0]  = 32'h200 + 32'(got);
            if (s_ready[0]) got++;
        end
        @(posedge clk);
        #2;
        check("pre-reset rcv_idx", 32'(rcv_idx[0]), 32'd12);
        check("pre-reset rcv_data", rcv_data[0], 32'h20B);
        check("pre-reset cycles", 32'(cycles[0]), 32'd12);
        reset      = 1'b1;
        s_valid[0] = 1'b0;
        #1;
        check_reset(0, "midjob");
        repeat (2) @(negedge clk);
        reset = 1'b0;
        run_job(0, 101, 1'b0, 0, 0, 1'b0, 2000, meas);
        check("j4 after reset cycles", 32'(cycles[0]), 32'd76);

        run_job(0, 51, 1'b0, 0, 400, 1'b0, 3000, meas);
        check("j5 stall400 cycles", 32'(cycles[0]), 32'd476);

        run_job(0, 1, 1'b0, 0, 65600, 1'b0, 70000, meas);
        check("j6 saturated cycles", 32'(cycles[0]), 32'hFFFF);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
